// File: rtl/vram_pkg.sv
// Shared constants and fill-sequencer state encoding for the character VRAM write side.
package vram_pkg;

  localparam int VRAM_COLS   = 40;
  localparam int VRAM_ROWS   = 30;
  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vram_fill_seq.sv
// Screen/row fill engine: FSM, row-range clamp and linear address counter.
// Row-range selection is compiled only when VRAM_CTL_ROWFILL_EN is defined.
module vram_fill_seq
  import vram_pkg::*;
#(
  parameter int COLS   = VRAM_COLS,
  parameter int ROWS   = VRAM_ROWS,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk25m,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        row0,
  input  logic [4:0]        row1,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              stall,
  output logic              want,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, done_q;

  logic [ADDR_W-1:0] range_first;
  logic [ADDR_W-1:0] range_limit;
  logic              range_empty;

`ifdef VRAM_CTL_ROWFILL_EN
  logic [4:0] row1_clamped;
  logic [5:0] row1_next;

  // limit is one past the last address of the final row, so it never exceeds ROWS*COLS
  always_comb begin
    row1_clamped = (int'(row1) >= ROWS) ? 5'(ROWS - 1) : row1;
    row1_next    = {1'b0, row1_clamped} + 6'd1;
    range_first  = ADDR_W'(row0) * ADDR_W'(COLS);
    range_limit  = ADDR_W'(row1_next) * ADDR_W'(COLS);
    range_empty  = (row0 > row1_clamped);
  end
`else
  logic unused_rows;

  assign range_first = '0;
  assign range_limit = ADDR_W'(ROWS * COLS);
  assign range_empty = 1'b0;
  assign unused_rows = ^{row0, row1};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    limit_d = limit_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = fill_data;
          addr_d  = range_first;
          limit_d = range_limit;
          state_d = range_empty ? ST_DONE : ST_FILL;
        end
      end
      // A host grant freezes the counter and also holds off completion by one cycle
      ST_FILL: begin
        if (!stall) begin
          if (addr_q == limit_q) state_d = ST_DONE;
          else                   addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      limit_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
      data_q  <= data_d;
      busy_q  <= (state_d == ST_FILL);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign want = (state_q == ST_FILL) && (addr_q != limit_q);
  assign addr = addr_q;
  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/vram_ctl.sv
// VRAM write-port arbiter: host handshake has priority over the fill engine.
// Build option VRAM_CTL_ROWFILL_EN enables row-range fills (else full-screen only).
module vram_ctl
  import vram_pkg::*;
#(
  parameter int COLS   = VRAM_COLS,
  parameter int ROWS   = VRAM_ROWS,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk25m,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              fill_start,
  input  logic [4:0]        fill_row0,
  input  logic [4:0]        fill_row1,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we
);

  logic              grant;
  logic              fill_want;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_byte;

  logic              vld_p1;
  logic              ack_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // A request seen during its own ack cycle is the same transaction, not a new one
  assign grant = host_req && !ack_p1;

  vram_fill_seq #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fill_seq (
    .clk25m    (clk25m),
    .rst_n     (rst_n),
    .start     (fill_start),
    .row0      (fill_row0),
    .row1      (fill_row1),
    .fill_data (fill_data),
    .stall     (grant),
    .want      (fill_want),
    .addr      (fill_addr),
    .data      (fill_byte),
    .busy      (fill_busy),
    .done      (fill_done)
  );

  // p1: registered write port
  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ack_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      ack_p1 <= grant;
      vld_p1 <= grant || fill_want;
      if (grant) begin
        addr_p1 <= host_addr;
        data_p1 <= host_data;
      end else if (fill_want) begin
        addr_p1 <= fill_addr;
        data_p1 <= fill_byte;
      end
    end
  end

  assign vram_we    = vld_p1;
  assign host_ack   = ack_p1;
  assign vram_waddr = addr_p1;
  assign vram_wdata = data_p1;

endmodule
